// File: rtl/voice_alloc.sv
// Polyphonic voice allocator: turns note on/off pulses into per-voice gate events,
// stealing the least recently allocated voice when every slot is busy.
module voice_alloc #(
  parameter int NVOICES = 8,
  parameter int VW      = 3
) (
  input  logic               clk96,
  input  logic               rst_n,
  input  logic               note_pressed,
  input  logic               note_released,
  input  logic [6:0]         note,
  input  logic [6:0]         velocity,
  input  logic [3:0]         channel,
  input  logic               panic,
  output logic               ev_valid,
  input  logic               ev_ready,
  output logic [VW-1:0]      ev_voice,
  output logic               ev_gate,
  output logic [6:0]         ev_note,
  output logic [6:0]         ev_velocity,
  output logic [NVOICES-1:0] voice_active,
  output logic               overflow
);

  typedef enum logic [1:0] {IDLE, LOOKUP, EMIT_OFF, EMIT_ON} state_t;

  state_t                       state;
  logic [NVOICES-1:0][6:0]      tnote;
  logic [NVOICES-1:0][3:0]      tchan;
  logic [NVOICES-1:0][VW-1:0]   tage;

  logic [6:0]    lat_note, lat_vel;
  logic [3:0]    lat_chan;
  logic          lat_press, pend_on;

  logic          do_press, do_rel;
  logic          hit, free;
  logic [VW-1:0] hit_idx, free_idx, old_idx, sel, max_age;

  // velocity 0 on a press is a release; a real press outranks a coincident release
  assign do_press = note_pressed && (velocity != 7'd0);
  assign do_rel   = note_released || (note_pressed && (velocity == 7'd0));

  always_comb begin
    hit = 1'b0; hit_idx = '0;
    free = 1'b0; free_idx = '0;
    for (int i = NVOICES-1; i >= 0; i--) begin
      if (voice_active[i] && tnote[i] == lat_note && tchan[i] == lat_chan) begin
        hit = 1'b1; hit_idx = VW'(i);
      end
      if (!voice_active[i]) begin
        free = 1'b1; free_idx = VW'(i);
      end
    end
    old_idx = '0; max_age = '0;
    for (int i = 0; i < NVOICES; i++) begin
      if (tage[i] > max_age) begin
        max_age = tage[i]; old_idx = VW'(i);
      end
    end
    sel = hit ? hit_idx : (free ? free_idx : old_idx);
  end

  always_ff @(posedge clk96 or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      tnote        <= '0;
      tchan        <= '0;
      tage         <= '0;
      voice_active <= '0;
      lat_note     <= '0;
      lat_vel      <= '0;
      lat_chan     <= '0;
      lat_press    <= 1'b0;
      pend_on      <= 1'b0;
      ev_valid     <= 1'b0;
      ev_voice     <= '0;
      ev_gate      <= 1'b0;
      ev_note      <= '0;
      ev_velocity  <= '0;
      overflow     <= 1'b0;
    end else if (panic) begin
      state        <= IDLE;
      voice_active <= '0;
      tage         <= '0;
      pend_on      <= 1'b0;
      ev_valid     <= 1'b0;
    end else begin
      if ((note_pressed || note_released) && state != IDLE)
        overflow <= 1'b1;
      case (state)
        IDLE: begin
          if (do_press || do_rel) begin
            lat_note  <= note;
            lat_vel   <= velocity;
            lat_chan  <= channel;
            lat_press <= do_press;
            state     <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (lat_press) begin
            // ages stay a dense 0..k-1 ranking of the active slots
            for (int i = 0; i < NVOICES; i++)
              if (voice_active[i] && VW'(i) != sel &&
                  (!voice_active[sel] || tage[i] < tage[sel]))
                tage[i] <= tage[i] + VW'(1);
            tage[sel]         <= '0;
            voice_active[sel] <= 1'b1;
            tnote[sel]        <= lat_note;
            tchan[sel]        <= lat_chan;
            ev_voice          <= sel;
            ev_valid          <= 1'b1;
            if (!hit && !free) begin
              ev_gate     <= 1'b0;
              ev_note     <= tnote[sel];
              ev_velocity <= '0;
              pend_on     <= 1'b1;
              state       <= EMIT_OFF;
            end else begin
              ev_gate     <= 1'b1;
              ev_note     <= lat_note;
              ev_velocity <= lat_vel;
              state       <= EMIT_ON;
            end
          end else if (hit) begin
            for (int i = 0; i < NVOICES; i++)
              if (voice_active[i] && VW'(i) != hit_idx && tage[i] > tage[hit_idx])
                tage[i] <= tage[i] - VW'(1);
            tage[hit_idx]         <= '0;
            voice_active[hit_idx] <= 1'b0;
            ev_voice    <= hit_idx;
            ev_gate     <= 1'b0;
            ev_note     <= lat_note;
            ev_velocity <= '0;
            ev_valid    <= 1'b1;
            pend_on     <= 1'b0;
            state       <= EMIT_OFF;
          end else begin
            state <= IDLE;
          end
        end
        EMIT_OFF: begin
          if (ev_ready) begin
            if (pend_on) begin
              ev_gate     <= 1'b1;
              ev_note     <= lat_note;
              ev_velocity <= lat_vel;
              pend_on     <= 1'b0;
              state       <= EMIT_ON;
            end else begin
              ev_valid <= 1'b0;
              state    <= IDLE;
            end
          end
        end
        EMIT_ON: begin
          if (ev_ready) begin
            ev_valid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_voice_alloc.sv
// Randomized bench for voice_alloc against an LRU slot-table model with an event queue.
module tb_voice_alloc;
  localparam int NV = 8;
  localparam int VW = 3;

  logic          clk96 = 1'b0, rst_n = 1'b0;
  logic          note_pressed = 1'b0, note_released = 1'b0, panic = 1'b0, ev_ready = 1'b1;
  logic [6:0]    note = '0, velocity = '0;
  logic [3:0]    channel = '0;
  logic          ev_valid, ev_gate, overflow;
  logic [VW-1:0] ev_voice;
  logic [6:0]    ev_note, ev_velocity;
  logic [NV-1:0] voice_active;
  logic [17:0]   cur_ev;

  int nchk = 0, nerr = 0;

  // model: slot contents plus a last-allocation timestamp per slot
  bit          m_act[NV];
  logic [6:0]  m_note[NV];
  logic [3:0]  m_chan[NV];
  int          m_stamp[NV];
  int          tick = 0;
  logic [17:0] exp_q[$];

  voice_alloc #(.NVOICES(NV), .VW(VW)) dut (
    .clk96(clk96), .rst_n(rst_n), .note_pressed(note_pressed), .note_released(note_released),
    .note(note), .velocity(velocity), .channel(channel), .panic(panic),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_voice(ev_voice), .ev_gate(ev_gate),
    .ev_note(ev_note), .ev_velocity(ev_velocity), .voice_active(voice_active), .overflow(overflow));

  always #5 clk96 = ~clk96;
  assign cur_ev = {ev_voice, ev_gate, ev_note, ev_velocity};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [NV-1:0] m_bitmap();
    logic [NV-1:0] b = '0;
    for (int i = 0; i < NV; i++) b[i] = m_act[i];
    return b;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NV; i++) m_act[i] = 1'b0;
  endtask

  task automatic model_apply(input bit p, input bit r, input logic [6:0] n, input logic [6:0] v,
                             input logic [3:0] c);
    int s;
    s = -1;
    for (int i = 0; i < NV; i++)
      if (s < 0 && m_act[i] && m_note[i] == n && m_chan[i] == c) s = i;
    if (p && v != 0) begin
      if (s < 0)
        for (int i = 0; i < NV; i++) if (s < 0 && !m_act[i]) s = i;
      if (s < 0) begin
        s = 0;
        for (int i = 1; i < NV; i++) if (m_stamp[i] < m_stamp[s]) s = i;
        exp_q.push_back({VW'(s), 1'b0, m_note[s], 7'd0});
      end
      m_act[s] = 1'b1; m_note[s] = n; m_chan[s] = c; m_stamp[s] = ++tick;
      exp_q.push_back({VW'(s), 1'b1, n, v});
    end else if ((p || r) && s >= 0) begin
      m_act[s] = 1'b0;
      exp_q.push_back({VW'(s), 1'b0, n, 7'd0});
    end
  endtask

  // one input pulse, latency checks, then drain the expected events
  task automatic send(input bit p, input bit r, input logic [6:0] n, input logic [6:0] v,
                      input logic [3:0] c, input bit rnd_rdy);
    int guard;
    bit stalled;
    logic [17:0] held;
    @(negedge clk96);
    note_pressed = p; note_released = r; note = n; velocity = v; channel = c;
    model_apply(p, r, n, v, c);
    @(negedge clk96);
    note_pressed = 1'b0; note_released = 1'b0;
    chk("lat1_valid", 32'(ev_valid), 32'd0);
    @(negedge clk96);
    chk("lat2_valid", 32'(ev_valid), 32'(exp_q.size() != 0));
    guard = 0; stalled = 1'b0; held = '0;
    while (exp_q.size() != 0 && guard < 100) begin
      if (stalled) chk("stable", 32'(cur_ev), 32'(held));
      ev_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (ev_valid && ev_ready) begin
        chk("event", 32'(cur_ev), 32'(exp_q.pop_front()));
        stalled = 1'b0;
      end else begin
        stalled = ev_valid; held = cur_ev;
      end
      @(negedge clk96);
      guard++;
    end
    if (guard >= 100) begin
      chk("timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    chk("idle_valid", 32'(ev_valid), 32'd0);
    chk("active", 32'(voice_active), 32'(m_bitmap()));
  endtask

  task automatic do_panic();
    @(negedge clk96); panic = 1'b1;
    @(negedge clk96); panic = 1'b0;
    model_clear();
    chk("panic_valid", 32'(ev_valid), 32'd0);
    chk("panic_active", 32'(voice_active), 32'd0);
  endtask

  initial begin
    logic [17:0] held;
    for (int i = 0; i < NV; i++) begin m_act[i] = 1'b0; m_stamp[i] = 0; m_note[i] = '0; m_chan[i] = '0; end
    #12;
    chk("reset_outs", 32'({ev_valid, ev_voice, ev_gate, ev_note, ev_velocity, voice_active, overflow}), 32'd0);
    rst_n = 1'b1;

    // basic press, release, non-playing release, vel-0 release, retrigger
    send(1, 0, 7'd60, 7'd100, 4'd0, 0);
    send(1, 0, 7'd60, 7'd0, 4'd0, 0);   // vel 0 acts as release
    send(1, 0, 7'd60, 7'd100, 4'd0, 0);
    send(0, 1, 7'd60, 7'd0, 4'd0, 0);
    send(0, 1, 7'd61, 7'd0, 4'd0, 0);
    send(1, 0, 7'd60, 7'd90, 4'd0, 1);
    send(1, 0, 7'd60, 7'd91, 4'd0, 1);
    chk("retrig_active", 32'(voice_active), 32'h01);

    // fill the table then steal
    for (int k = 60; k < 68; k++) send(1, 0, 7'(k), 7'(k - 20), 4'd0, 1);
    send(1, 1, 7'd72, 7'd33, 4'd0, 1);  // coincident release ignored
    chk("full_active", 32'(voice_active), 32'hFF);

    // panic mid-emit with a coinciding pulse
    do_panic();
    for (int k = 0; k < 4; k++) send(1, 0, 7'(40 + k), 7'd10, 4'd1, 1);
    ev_ready = 1'b0;
    @(negedge clk96); note_pressed = 1'b1; note = 7'd50; velocity = 7'd5; channel = 4'd1;
    @(negedge clk96); note_pressed = 1'b0;
    @(negedge clk96);
    chk("pre_panic_valid", 32'(ev_valid), 32'd1);
    panic = 1'b1; note_pressed = 1'b1;
    @(negedge clk96); panic = 1'b0; note_pressed = 1'b0;
    model_clear();
    chk("panic_mid_valid", 32'(ev_valid), 32'd0);
    chk("panic_mid_active", 32'(voice_active), 32'd0);
    chk("panic_no_ovf", 32'(overflow), 32'd0);

    // randomized traffic
    for (int t = 0; t < 150; t++) begin
      bit p, r;
      p = ($urandom_range(0, 9) < 6);
      r = p ? ($urandom_range(0, 7) == 0) : 1'b1;
      send(p, r, 7'(60 + $urandom_range(0, 5)),
           ($urandom_range(0, 7) == 0) ? 7'd0 : 7'($urandom_range(1, 127)),
           4'($urandom_range(0, 1)), 1);
    end
    chk("rand_no_ovf", 32'(overflow), 32'd0);

    // stall with a dropped second press
    do_panic();
    ev_ready = 1'b0;
    @(negedge clk96); note_pressed = 1'b1; note = 7'd60; velocity = 7'd100; channel = 4'd0;
    model_apply(1, 0, 7'd60, 7'd100, 4'd0);
    @(negedge clk96); note_pressed = 1'b0;
    @(negedge clk96);
    held = cur_ev;
    chk("stall_valid", 32'(ev_valid), 32'd1);
    note_pressed = 1'b1; note = 7'd62; velocity = 7'd50;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk96); note_pressed = 1'b0;
      chk("stall_stable", 32'({ev_valid, cur_ev}), 32'({1'b1, held}));
    end
    chk("stall_ovf", 32'(overflow), 32'd1);
    chk("stall_event", 32'(held), 32'(exp_q.pop_front()));
    ev_ready = 1'b1;
    @(negedge clk96);
    chk("stall_done", 32'(ev_valid), 32'd0);
    @(negedge clk96);
    chk("stall_single", 32'(ev_valid), 32'd0);
    chk("stall_active", 32'(voice_active), 32'h01);

    // async reset mid-operation
    ev_ready = 1'b0;
    @(negedge clk96); note_pressed = 1'b1; note = 7'd70; velocity = 7'd9;
    @(negedge clk96); note_pressed = 1'b0;
    @(negedge clk96);
    rst_n = 1'b0;
    #1;
    chk("async_reset", 32'({ev_valid, ev_voice, ev_gate, ev_note, ev_velocity, voice_active, overflow}), 32'd0);
    #20;
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
